// File: rtl/mod_acc_sequencer.sv
// Accumulator command sequencer wrapped around a combinational modular adder/subtractor.
// Adds clear, load, add, subtract and multiply-by-scalar via repeated modular addition.
module mod_acc_sequencer #(
    parameter logic [3:0] M = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [3:0] operand,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] acc,
    output logic       err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_CLR  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;

    state_t     state, state_nx;
    logic [3:0] acc_nx;
    logic       err_nx;
    logic [3:0] k, k_nx;
    logic [3:0] base, base_nx;

    logic       main_s;
    logic [3:0] main_x, main_y, main_z;
    logic [4:0] sum, sum_red;
    logic [3:0] diff;
    logic       accept, bad;

    // MAIN: both operands are already reduced, so one correction step suffices
    always_comb begin
        sum     = {1'b0, main_x} + {1'b0, main_y};
        sum_red = sum - {1'b0, M};
        diff    = main_x - main_y;
        if (main_s)
            main_z = (main_x < main_y) ? diff + M : diff;
        else
            main_z = (sum >= {1'b0, M}) ? sum_red[3:0] : sum[3:0];
    end

    assign main_s = (state == IDLE) && (op == OP_SUB);
    assign main_x = acc;
    assign main_y = (state == EXEC) ? base : operand;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign bad       = (op > OP_MUL) || ((op != OP_CLR) && (operand >= M));

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        err_nx   = err;
        k_nx     = k;
        base_nx  = base;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    err_nx   = bad;
                    state_nx = RESP;
                    if (!bad) begin
                        case (op)
                            OP_CLR:         acc_nx = '0;
                            OP_LOAD:        acc_nx = operand;
                            OP_ADD, OP_SUB: acc_nx = main_z;
                            default: begin
                                acc_nx  = '0;
                                k_nx    = operand;
                                base_nx = acc;
                                if (operand != 4'd0)
                                    state_nx = EXEC;
                            end
                        endcase
                    end
                end
            end
            EXEC: begin
                acc_nx = main_z;
                k_nx   = k - 4'd1;
                if (k == 4'd1)
                    state_nx = RESP;
            end
            RESP: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            err   <= 1'b0;
            k     <= '0;
            base  <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            err   <= err_nx;
            k     <= k_nx;
            base  <= base_nx;
        end
    end
endmodule

// File: tb/tb_mod_acc_sequencer.sv
// Bench for mod_acc_sequencer: one instance per modulus 9..15 (index i -> M=9+i),
// checked against an integer reference model of the command set.
module tb_mod_acc_sequencer;
    localparam int NI = 7;

    logic       clk = 1'b0;
    logic       rst       [NI];
    logic       in_valid  [NI];
    logic       in_ready  [NI];
    logic [2:0] op        [NI];
    logic [3:0] operand   [NI];
    logic       out_valid [NI];
    logic       out_ready [NI];
    logic [3:0] acc       [NI];
    logic       err       [NI];
    logic       busy      [NI];

    int checks = 0;
    int errors = 0;
    int model_acc [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam logic [3:0] MG = 4'(9 + g);
        mod_acc_sequencer #(.M(MG)) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .op        (op[g]),
            .operand   (operand[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .acc       (acc[g]),
            .err       (err[g]),
            .busy      (busy[g])
        );
    end

    // Reference: what one command does to the accumulator, err and latency
    function automatic void ref_step(input int m, input int a, input int o,
                                     input int v, output int na, output int ne,
                                     output int lat);
        na  = a;
        ne  = 0;
        lat = 1;
        if (o > 4 || (o != 0 && v >= m)) begin
            ne = 1;
        end else begin
            case (o)
                0: na = 0;
                1: na = v;
                2: na = (a + v) % m;
                3: na = (a - v + m) % m;
                default: begin
                    na  = (a * v) % m;
                    lat = v + 1;
                end
            endcase
        end
    endfunction

    // Issue one command from IDLE; return at the negedge where out_valid is seen
    task automatic do_cmd(input int i, input int o, input int v, output int lat);
        op[i]       = o[2:0];
        operand[i]  = v[3:0];
        in_valid[i] = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid[i] = 1'b0;
        while (!out_valid[i] && lat <= 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_resp();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0;
            model_acc[i] = 0;
        end
        for (int i = 0; i < NI; i++) begin
            checks += 5;
            if (acc[i] !== 4'd0) begin
                errors++; $display("FAIL reset_acc[%0d]: got %0d want 0", i, acc[i]);
            end
            if (out_valid[i] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]);
            end
            if (err[i] !== 1'b0) begin
                errors++; $display("FAIL reset_err[%0d]: got %b want 0", i, err[i]);
            end
            if (busy[i] !== 1'b0) begin
                errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]);
            end
            if (in_ready[i] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]);
            end
        end
    endtask

    task automatic test_add();
        int lat;
        do_cmd(6, 1, 7, lat);
        checks += 2;
        if (acc[6] !== 4'd7) begin
            errors++; $display("FAIL add_load: got %0d want 7", acc[6]);
        end
        if (lat != 1) begin
            errors++; $display("FAIL add_load_lat: got %0d want 1", lat);
        end
        finish_resp();
        do_cmd(6, 2, 12, lat);
        checks += 3;
        if (acc[6] !== 4'd4) begin
            errors++; $display("FAIL add_wrap: got %0d want 4", acc[6]);
        end
        if (err[6] !== 1'b0) begin
            errors++; $display("FAIL add_err: got %b want 0", err[6]);
        end
        if (lat != 1) begin
            errors++; $display("FAIL add_lat: got %0d want 1", lat);
        end
        finish_resp();
    endtask

    task automatic test_sub_wrap();
        int lat;
        do_cmd(6, 1, 3, lat);
        finish_resp();
        do_cmd(6, 3, 5, lat);
        checks++;
        if (acc[6] !== 4'd13) begin
            errors++; $display("FAIL sub_wrap: got %0d want 13", acc[6]);
        end
        finish_resp();
        do_cmd(6, 3, 13, lat);
        checks++;
        if (acc[6] !== 4'd0) begin
            errors++; $display("FAIL sub_zero: got %0d want 0", acc[6]);
        end
        finish_resp();
        model_acc[6] = 0;
    endtask

    task automatic test_mul();
        int lat;
        bit busy_ok;
        do_cmd(0, 1, 5, lat);
        finish_resp();
        op[0] = 3'd4;
        operand[0] = 4'd7;
        in_valid[0] = 1'b1;
        @(posedge clk);
        lat = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        while (!out_valid[0] && lat <= 40) begin
            if (busy[0] !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks += 4;
        if (lat != 8) begin
            errors++; $display("FAIL mul_lat: got %0d want 8", lat);
        end
        if (!busy_ok || busy[0] !== 1'b1) begin
            errors++; $display("FAIL mul_busy: got %b want 1", busy[0]);
        end
        if (acc[0] !== 4'd8) begin
            errors++; $display("FAIL mul_acc: got %0d want 8", acc[0]);
        end
        if (err[0] !== 1'b0) begin
            errors++; $display("FAIL mul_err: got %b want 0", err[0]);
        end
        finish_resp();
        do_cmd(0, 4, 0, lat);
        checks += 2;
        if (lat != 1) begin
            errors++; $display("FAIL mul0_lat: got %0d want 1", lat);
        end
        if (acc[0] !== 4'd0) begin
            errors++; $display("FAIL mul0_acc: got %0d want 0", acc[0]);
        end
        finish_resp();
    endtask

    task automatic test_reject();
        int lat;
        do_cmd(0, 1, 4, lat);
        finish_resp();
        do_cmd(0, 1, 9, lat);
        checks += 2;
        if (err[0] !== 1'b1) begin
            errors++; $display("FAIL rej_load_err: got %b want 1", err[0]);
        end
        if (acc[0] !== 4'd4) begin
            errors++; $display("FAIL rej_load_acc: got %0d want 4", acc[0]);
        end
        finish_resp();
        do_cmd(0, 6, 0, lat);
        checks += 2;
        if (err[0] !== 1'b1) begin
            errors++; $display("FAIL rej_op_err: got %b want 1", err[0]);
        end
        if (acc[0] !== 4'd4) begin
            errors++; $display("FAIL rej_op_acc: got %0d want 4", acc[0]);
        end
        finish_resp();
        do_cmd(0, 0, 15, lat);
        checks += 2;
        if (err[0] !== 1'b0) begin
            errors++; $display("FAIL clr_err: got %b want 0", err[0]);
        end
        if (acc[0] !== 4'd0) begin
            errors++; $display("FAIL clr_acc: got %0d want 0", acc[0]);
        end
        finish_resp();
        model_acc[0] = 0;
    endtask

    task automatic test_stall();
        int lat;
        do_cmd(6, 1, 2, lat);
        finish_resp();
        out_ready[6] = 1'b0;
        do_cmd(6, 2, 5, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid[6] = (c % 2 == 0);
            op[6] = 3'd1;
            operand[6] = 4'd1;
            @(posedge clk);
            @(negedge clk);
            checks += 3;
            if (out_valid[6] !== 1'b1) begin
                errors++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_valid[6]);
            end
            if (acc[6] !== 4'd7) begin
                errors++; $display("FAIL stall_acc[%0d]: got %0d want 7", c, acc[6]);
            end
            if (in_ready[6] !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready[6]);
            end
        end
        in_valid[6] = 1'b0;
        out_ready[6] = 1'b1;
        finish_resp();
        checks += 2;
        if (in_ready[6] !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b want 1", in_ready[6]);
        end
        if (out_valid[6] !== 1'b0) begin
            errors++; $display("FAIL release_valid: got %b want 0", out_valid[6]);
        end
        do_cmd(6, 1, 3, lat);
        checks += 2;
        if (acc[6] !== 4'd3) begin
            errors++; $display("FAIL after_stall_acc: got %0d want 3", acc[6]);
        end
        if (lat != 1) begin
            errors++; $display("FAIL after_stall_lat: got %0d want 1", lat);
        end
        finish_resp();
        model_acc[6] = 3;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        bit stale;
        do_cmd(6, 1, 14, lat);
        finish_resp();
        op[6] = 3'd4;
        operand[6] = 4'd10;
        in_valid[6] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[6] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy[6] !== 1'b1 || out_valid[6] !== 1'b0) begin
            errors++; $display("FAIL mid_mul_exec: busy %b valid %b want 1 0", busy[6], out_valid[6]);
        end
        rst[6] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[6] = 1'b0;
        checks += 4;
        if (acc[6] !== 4'd0) begin
            errors++; $display("FAIL abort_acc: got %0d want 0", acc[6]);
        end
        if (out_valid[6] !== 1'b0) begin
            errors++; $display("FAIL abort_valid: got %b want 0", out_valid[6]);
        end
        if (in_ready[6] !== 1'b1) begin
            errors++; $display("FAIL abort_in_ready: got %b want 1", in_ready[6]);
        end
        if (busy[6] !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got %b want 0", busy[6]);
        end
        stale = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[6] !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++; $display("FAIL abort_stale: got 1 want 0");
        end
        model_acc[6] = 0;
    endtask

    task automatic test_exhaustive();
        int lat, na, ne, el, m;
        for (int i = 0; i < NI; i++) begin
            m = 9 + i;
            for (int x = 0; x < m; x++) begin
                for (int y = 0; y < m; y++) begin
                    do_cmd(i, 1, x, lat);
                    finish_resp();
                    ref_step(m, x, 2, y, na, ne, el);
                    do_cmd(i, 2, y, lat);
                    checks++;
                    if (acc[i] !== 4'(na)) begin
                        errors++;
                        $display("FAIL ex_add m=%0d %0d+%0d: got %0d want %0d", m, x, y, acc[i], na);
                    end
                    finish_resp();
                    ref_step(m, na, 3, y, na, ne, el);
                    do_cmd(i, 3, y, lat);
                    checks++;
                    if (acc[i] !== 4'(na)) begin
                        errors++;
                        $display("FAIL ex_sub m=%0d y=%0d: got %0d want %0d", m, y, acc[i], na);
                    end
                    finish_resp();
                    model_acc[i] = na;
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, na, ne, el, m, o, v, stall;
        logic [3:0] held;
        for (int i = 0; i < NI; i++) begin
            m = 9 + i;
            for (int n = 0; n < 40; n++) begin
                o = $urandom_range(0, 7);
                v = $urandom_range(0, 15);
                stall = $urandom_range(0, 2);
                ref_step(m, model_acc[i], o, v, na, ne, el);
                out_ready[i] = (stall == 0);
                do_cmd(i, o, v, lat);
                checks += 3;
                if (lat != el) begin
                    errors++; $display("FAIL rnd_lat m=%0d op=%0d v=%0d: got %0d want %0d", m, o, v, lat, el);
                end
                if (acc[i] !== 4'(na)) begin
                    errors++; $display("FAIL rnd_acc m=%0d op=%0d v=%0d: got %0d want %0d", m, o, v, acc[i], na);
                end
                if (err[i] !== ne[0]) begin
                    errors++; $display("FAIL rnd_err m=%0d op=%0d v=%0d: got %b want %0d", m, o, v, err[i], ne);
                end
                held = acc[i];
                if (stall > 0) begin
                    repeat (stall) @(posedge clk);
                    @(negedge clk);
                    checks++;
                    if (acc[i] !== held || out_valid[i] !== 1'b1) begin
                        errors++; $display("FAIL rnd_hold m=%0d: acc %0d valid %b want %0d 1", m, acc[i], out_valid[i], held);
                    end
                    out_ready[i] = 1'b1;
                end
                finish_resp();
                model_acc[i] = na;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            in_valid[i] = 1'b0;
            op[i] = 3'd0;
            operand[i] = 4'd0;
            out_ready[i] = 1'b1;
        end
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_wrap();
        test_mul();
        test_reject();
        test_stall();
        test_reset_mid_mul();
        test_exhaustive();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
